tx_frame_scheduler: RTL and testbench

Round-robin frame scheduler for the transmit path. It shares the byte-wide serializer input between the three per-channel input buffers. Each time a channel is granted, the block reads one fixed-length burst from that channel's buffer and wraps it as a frame: header byte, payload bytes, XOR checksum byte. When no channel is eligible it emits idle bytes. It sits between the input buffers' read side and the LVDS transmitter's parallel input, and runs on the serializer's data clock.

---
 rtl/tx_frame_scheduler.sv | 159 +++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// Round-robin frame scheduler: grants one channel at a time and wraps a fixed
// burst from its buffer as header, payload and XOR checksum bytes.
module tx_frame_scheduler #(
  parameter int              NCH       = 3,
  parameter int              DW        = 8,
  parameter int              BURST     = 4,
  parameter logic [5:0]      HDR_TAG   = 6'b101001,
  parameter logic [DW-1:0]   IDLE_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [NCH-1:0]    input_ready,
  input  logic [NCH-1:0]    channel_enable,
  input  logic [NCH*DW-1:0] input_data,
  output logic [NCH-1:0]    read_req,
  output logic [DW-1:0]     output_data,
  output logic              output_valid,
  output logic [1:0]        grant_id,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;

  state_t          state_q, state_n;
  logic [1:0]      last_q, last_n;
  logic [1:0]      grant_q, grant_n;
  logic [7:0]      cnt_q, cnt_n;
  logic [DW-1:0]   chk_q, chk_n;
  logic [DW-1:0]   byte_q, byte_n;
  logic            vld_q, vld_n;
  logic [NCH-1:0]  rr_q, rr_n;
  logic [15:0]     fc_q, fc_n;

  logic [NCH-1:0]  eligible;
  logic [DW-1:0]   lanes [NCH];
  logic [DW-1:0]   pay_byte;
  logic [DW-1:0]   hdr_byte;
  logic [NCH-1:0]  win_onehot;
  logic            win_found;
  logic [1:0]      win_id;

  assign eligible = input_ready & channel_enable;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      lanes[c] = input_data[c*DW +: DW];
    end
  end

  assign pay_byte = lanes[grant_q];

  // Round-robin search starting just after the last granted channel
  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = 2'((int'(last_q) + i) % NCH);
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign hdr_byte   = {HDR_TAG, win_id};
  assign win_onehot = NCH'(1) << win_id;

  always_comb begin
    state_n = state_q;
    last_n  = last_q;
    grant_n = grant_q;
    cnt_n   = cnt_q;
    chk_n   = chk_q;
    byte_n  = byte_q;
    vld_n   = vld_q;
    rr_n    = rr_q;
    fc_n    = fc_q;
    case (state_q)
      IDLE, CHK: begin
        if (state_q == CHK) begin
          fc_n = fc_q + 16'd1;
        end
        if (win_found) begin
          state_n = HDR;
          grant_n = win_id;
          last_n  = win_id;
          byte_n  = hdr_byte;
          chk_n   = hdr_byte;
          vld_n   = 1'b1;
          rr_n    = win_onehot;
        end else begin
          state_n = IDLE;
          byte_n  = IDLE_BYTE;
          vld_n   = 1'b0;
          rr_n    = '0;
        end
      end
      HDR: begin
        state_n = PAY;
        cnt_n   = '0;
        vld_n   = 1'b1;
        if (BURST <= 1) begin
          rr_n = '0;
        end
      end
      PAY: begin
        chk_n = chk_q ^ pay_byte;
        if (cnt_q == 8'(BURST-1)) begin
          state_n = CHK;
          byte_n  = chk_q ^ pay_byte;
          rr_n    = '0;
        end else begin
          cnt_n = cnt_q + 8'd1;
          // The buffer answers one cycle late, so the last payload cycle needs no strobe
          if (cnt_n >= 8'(BURST-1)) begin
            rr_n = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      last_q  <= 2'(NCH-1);
      grant_q <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      byte_q  <= IDLE_BYTE;
      vld_q   <= 1'b0;
      rr_q    <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_n;
      last_q  <= last_n;
      grant_q <= grant_n;
      cnt_q   <= cnt_n;
      chk_q   <= chk_n;
      byte_q  <= byte_n;
      vld_q   <= vld_n;
      rr_q    <= rr_n;
      fc_q    <= fc_n;
    end
  end

  // Payload bytes come straight from the buffer's registered read port
  assign output_data  = (state_q == PAY) ? pay_byte : byte_q;
  assign output_valid = vld_q;
  assign read_req     = rr_q;
  assign grant_id     = grant_q;
  assign frame_count  = fc_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Randomized scoreboard bench for tx_frame_scheduler: a frame-level model plans
// the expected output stream, a monitor compares it cycle by cycle.
module tb_tx_frame_scheduler;
  localparam int            NCH       = 3;
  localparam int            DW        = 8;
  localparam int            BURST     = 4;
  localparam logic [5:0]    HDR_TAG   = 6'b101001;
  localparam logic [DW-1:0] IDLE_BYTE = 8'h00;
  localparam int            DEPTH     = 4096;
  localparam int            NCYC      = 3000;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic [NCH-1:0]    input_ready = '0;
  logic [NCH-1:0]    channel_enable = '0;
  logic [NCH*DW-1:0] input_data;
  logic [NCH-1:0]    read_req;
  logic [DW-1:0]     output_data;
  logic              output_valid;
  logic [1:0]        grant_id;
  logic [15:0]       frame_count;

  tx_frame_scheduler #(
    .NCH(NCH), .DW(DW), .BURST(BURST), .HDR_TAG(HDR_TAG), .IDLE_BYTE(IDLE_BYTE)
  ) dut (
    .clk(clk), .arst(arst), .input_ready(input_ready), .channel_enable(channel_enable),
    .input_data(input_data), .read_req(read_req), .output_data(output_data),
    .output_valid(output_valid), .grant_id(grant_id), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Per-channel buffer contents and read side: data appears the cycle after read_req
  logic [DW-1:0] mem [NCH][DEPTH];
  int            rd_ptr [NCH] = '{default: 0};
  logic [DW-1:0] data_r [NCH];

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (read_req[c]) begin
        data_r[c] <= mem[c][rd_ptr[c] % DEPTH];
        rd_ptr[c] <= rd_ptr[c] + 1;
      end
    end
  end

  always_comb begin
    input_data = '0;
    for (int c = 0; c < NCH; c++) begin
      input_data[c*DW +: DW] = data_r[c];
    end
  end

  typedef struct {
    int             cyc;
    bit             vld;
    logic [DW-1:0]  data;
    logic [NCH-1:0] rr;
    logic [15:0]    fc;
    bit             chk_gid;
    logic [1:0]     gid;
  } exp_t;

  exp_t        exp_q[$];
  int          cur_cyc = -1;
  int          planned = -1;
  int          last_m = NCH - 1;
  logic [15:0] fc_m = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic exp_t mk(int cyc, bit vld, logic [DW-1:0] data, logic [NCH-1:0] rr,
                              logic [15:0] fc, bit chk_gid, logic [1:0] gid);
    exp_t e;
    e.cyc = cyc; e.vld = vld; e.data = data; e.rr = rr;
    e.fc = fc; e.chk_gid = chk_gid; e.gid = gid;
    return e;
  endfunction

  // Decide what follows cycle n from the eligibility seen during cycle n
  task automatic plan_next(input int n);
    logic [NCH-1:0] elig;
    logic [NCH-1:0] oh;
    logic [DW-1:0]  hdr, b, sum;
    int             win;
    elig = input_ready & channel_enable;
    win  = -1;
    for (int i = 1; i <= NCH; i++) begin
      if (win < 0 && elig[(last_m + i) % NCH]) win = (last_m + i) % NCH;
    end
    if (win < 0) begin
      exp_q.push_back(mk(n + 1, 1'b0, IDLE_BYTE, '0, fc_m, 1'b0, 2'd0));
      planned = n + 1;
    end else begin
      oh  = '0;
      oh[win] = 1'b1;
      hdr = {HDR_TAG, 2'(win)};
      sum = hdr;
      exp_q.push_back(mk(n + 1, 1'b1, hdr, oh, fc_m, 1'b1, 2'(win)));
      for (int k = 0; k < BURST; k++) begin
        b   = mem[win][(rd_ptr[win] + k) % DEPTH];
        sum = sum ^ b;
        exp_q.push_back(mk(n + 2 + k, 1'b1, b, (k < BURST - 1) ? oh : '0, fc_m, 1'b1, 2'(win)));
      end
      exp_q.push_back(mk(n + 2 + BURST, 1'b1, sum, '0, fc_m, 1'b1, 2'(win)));
      fc_m    = fc_m + 16'd1;
      last_m  = win;
      planned = n + 2 + BURST;
    end
  endtask

  initial begin
    bit rst_now;
    int phase;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < DEPTH; i++) mem[c][i] = DW'($urandom);
    end
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      cur_cyc = n;
      rst_now = (n < 3) || ($urandom_range(0, 249) == 0);
      arst    = rst_now;
      phase   = (n / 400) % 4;
      case (phase)
        0: begin
          input_ready    = NCH'($urandom);
          channel_enable = NCH'($urandom) | NCH'($urandom);
        end
        1: begin
          input_ready    = '1;
          channel_enable = '1;
        end
        2: begin
          input_ready    = '1;
          channel_enable = 3'b101;
        end
        default: begin
          for (int c = 0; c < NCH; c++) input_ready[c] = ($urandom_range(0, 7) == 0);
          channel_enable = '1;
        end
      endcase
      if (rst_now) begin
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > n) void'(exp_q.pop_back());
        exp_q.push_back(mk(n + 1, 1'b0, IDLE_BYTE, '0, 16'd0, 1'b1, 2'd0));
        planned = n + 1;
        last_m  = NCH - 1;
        fc_m    = '0;
      end else if (planned <= n) begin
        plan_next(n);
      end
    end
    @(posedge clk);
    #1;
    cur_cyc = NCYC;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cur_cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (output_valid !== e.vld || output_data !== e.data || read_req !== e.rr ||
            frame_count !== e.fc || (e.chk_gid && grant_id !== e.gid)) begin
          n_bad++;
          $display("FAIL cycle_%0d: got vld=%0b data=%02h rr=%b fc=%0d gid=%0d, expected vld=%0b data=%02h rr=%b fc=%0d gid=%0d",
                   cur_cyc, output_valid, output_data, read_req, frame_count, grant_id,
                   e.vld, e.data, e.rr, e.fc, e.gid);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cur_cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stale_expectation: cycle %0d still pending at cycle %0d", exp_q[0].cyc, cur_cyc);
        void'(exp_q.pop_front());
      end
    end
  end

endmodule
